hilo_div_ctrl: RTL and testbench

Execute-stage sequencer for the CPU's DIV/DIVU/MTHI/MTLO instructions. It accepts operations from the EX stage and latches divide operands so they stay stable for the whole iteration. It drives the iterative divider (33 active cycles per divide), stalls the pipeline until the quotient and remainder are captured, and owns the architectural HI/LO registers that MFHI/MFLO read.

---
 rtl/hilo_div_ctrl_if.sv | 35 +++
 rtl/hilo_div_ctrl.sv | 106 ++++++++++
 tb/tb_hilo_div_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_div_ctrl_if.sv
// EX-stage and divider-side signals of the HI/LO divide sequencer.
// slave: the sequencer itself; master: the pipeline/divider environment driving it.
interface hilo_div_ctrl_if;
    logic        op_valid;
    logic        op_div;
    logic        op_divu;
    logic        op_mthi;
    logic        op_mtlo;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cancel;
    logic        md_stall;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_signed;
    logic        div_start;
    logic        div_abort;
    logic [31:0] div_s;
    logic [31:0] div_r;
    logic        div_complete;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  op_valid, op_div, op_divu, op_mthi, op_mtlo, op_a, op_b, cancel,
        input  div_s, div_r, div_complete,
        output md_stall, div_x, div_y, div_signed, div_start, div_abort, hi, lo
    );

    modport master (
        output op_valid, op_div, op_divu, op_mthi, op_mtlo, op_a, op_b, cancel,
        output div_s, div_r, div_complete,
        input  md_stall, div_x, div_y, div_signed, div_start, div_abort, hi, lo
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequencer for DIV/DIVU/MTHI/MTLO: latches operands, runs the iterative divider, owns HI/LO.
// Optional macro DIV_ZERO_SKIP_EN: divides with a zero divisor are not issued to the divider.
module hilo_div_ctrl (
    input  logic            clk,
    input  logic            resetn,
    hilo_div_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        sgn_q, sgn_d;
    logic        start_q, start_d;
    logic        is_div;
    logic        go;
    logic        stall;
    logic        abort;

    always_comb begin
        is_div = bus.op_valid & (bus.op_div | bus.op_divu) & ~bus.cancel;
`ifdef DIV_ZERO_SKIP_EN
        go = is_div & (bus.op_b != 32'd0);
`else
        go = is_div;
`endif
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        x_d     = x_q;
        y_d     = y_q;
        sgn_d   = sgn_q;
        start_d = start_q;
        stall   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = go;
                if (go) begin
                    x_d     = bus.op_a;
                    y_d     = bus.op_b;
                    sgn_d   = bus.op_div;
                    start_d = 1'b1;
                    state_d = RUN;
                end
                if (bus.op_valid & ~bus.cancel & bus.op_mthi) hi_d = bus.op_a;
                if (bus.op_valid & ~bus.cancel & bus.op_mtlo) lo_d = bus.op_a;
            end
            RUN: begin
                stall = 1'b1;
                // A flush wins even if the divider finishes in the same cycle.
                if (bus.cancel) begin
                    abort   = 1'b1;
                    start_d = 1'b0;
                    state_d = IDLE;
                end else if (bus.div_complete) begin
                    lo_d    = bus.div_s;
                    hi_d    = bus.div_r;
                    start_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            sgn_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            start_q <= start_d;
        end
    end

    assign bus.md_stall   = stall;
    assign bus.div_abort  = abort;
    assign bus.div_start  = start_q;
    assign bus.div_x      = x_q;
    assign bus.div_y      = y_q;
    assign bus.div_signed = sgn_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: behavioural divider, cycle-timeline reference model,
// directed scenarios with literal expectations and a randomized operation stream.
module tb_hilo_div_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    hilo_div_ctrl_if bus ();

    hilo_div_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int stall_seen = 0;
    int abort_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division: truncation toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        longint sx, sy, q, r;
        if (y == 32'd0) return {32'hFFFF_FFFF, x};
        if (!sgn) return {x / y, x % y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q = sx / sy;
        r = sx - q * sy;
        return {q[31:0], r[31:0]};
    endfunction

    // Behavioural divider: completes when its iteration count reaches 32.
    int unsigned dcnt;
    logic [63:0] dres;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) dcnt <= 0;
        else if (bus.div_abort || !bus.div_start) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end
    always_comb begin
        dres = ref_div(bus.div_x, bus.div_y, bus.div_signed);
        bus.div_s = dres[63:32];
        bus.div_r = dres[31:0];
        bus.div_complete = bus.div_start && (dcnt == 32);
    end

    // Reference model: a divide accepted in cycle t stalls t..t+33, runs t+1..t+33,
    // results visible from t+34 (the one-cycle DONE slot, which never re-accepts).
    int          run_left = 0;
    bit          done_cyc = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_x = 0, m_y = 0, p_q = 0, p_r = 0;
    logic        m_sgn = 0;
    logic [63:0] m_res;
    logic        e_stall, e_start, e_abort;
    bit          acc;

    always @(negedge clk) begin
        if (!resetn) begin
            run_left = 0; done_cyc = 0;
            m_hi = 0; m_lo = 0; m_x = 0; m_y = 0; m_sgn = 0;
            chk("rst_hi", bus.hi, 32'd0);
            chk("rst_lo", bus.lo, 32'd0);
            chk("rst_stall", {31'd0, bus.md_stall}, 32'd0);
            chk("rst_start", {31'd0, bus.div_start}, 32'd0);
            chk("rst_abort", {31'd0, bus.div_abort}, 32'd0);
            chk("rst_x", bus.div_x, 32'd0);
            chk("rst_y", bus.div_y, 32'd0);
        end else begin
            acc = 0;
            if (run_left > 0) begin
                e_stall = 1; e_start = 1; e_abort = bus.cancel;
            end else if (done_cyc) begin
                e_stall = 0; e_start = 0; e_abort = 0;
            end else begin
                acc = bus.op_valid && (bus.op_div || bus.op_divu) && !bus.cancel;
`ifdef DIV_ZERO_SKIP_EN
                acc = acc && (bus.op_b != 32'd0);
`endif
                e_stall = acc; e_start = 0; e_abort = 0;
            end
            chk("md_stall", {31'd0, bus.md_stall}, {31'd0, e_stall});
            chk("div_start", {31'd0, bus.div_start}, {31'd0, e_start});
            chk("div_abort", {31'd0, bus.div_abort}, {31'd0, e_abort});
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
            chk("div_x", bus.div_x, m_x);
            chk("div_y", bus.div_y, m_y);
            chk("div_signed", {31'd0, bus.div_signed}, {31'd0, m_sgn});
            if (bus.md_stall) stall_seen++;
            if (bus.div_abort) abort_seen++;

            if (run_left > 0) begin
                if (bus.cancel) run_left = 0;
                else begin
                    run_left--;
                    if (run_left == 0) begin
                        m_hi = p_r; m_lo = p_q; done_cyc = 1;
                    end
                end
            end else if (done_cyc) begin
                done_cyc = 0;
            end else begin
                if (acc) begin
                    m_x = bus.op_a; m_y = bus.op_b; m_sgn = bus.op_div;
                    m_res = ref_div(bus.op_a, bus.op_b, bus.op_div);
                    p_q = m_res[63:32]; p_r = m_res[31:0];
                    run_left = 33;
                end
                if (bus.op_valid && !bus.cancel && bus.op_mthi) m_hi = bus.op_a;
                if (bus.op_valid && !bus.cancel && bus.op_mtlo) m_lo = bus.op_a;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.op_valid = 0; bus.op_div = 0; bus.op_divu = 0;
        bus.op_mthi = 0; bus.op_mtlo = 0; bus.cancel = 0;
        bus.op_a = 0; bus.op_b = 0;
    endtask

    // cancel_at: 0 none, -1 in the accept cycle, k in RUN cycle k. reset_at: RUN cycle k or 0.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int reset_at);
        stall_seen = 0;
        abort_seen = 0;
        bus.op_valid = 1; bus.op_div = sgn; bus.op_divu = !sgn;
        bus.op_mthi = 0; bus.op_mtlo = 0;
        bus.op_a = a; bus.op_b = b; bus.cancel = (cancel_at == -1);
        if (cancel_at == -1) begin
            step(); idle_in(); return;
        end
        for (int c = 1; c <= 34; c++) begin
            step();
            if (c == cancel_at) begin
                bus.cancel = 1;
                step(); idle_in(); return;
            end
            if (c == reset_at) begin
                resetn = 0;
                idle_in();
                #1;
                chk("arst_hi", bus.hi, 32'd0);
                chk("arst_lo", bus.lo, 32'd0);
                chk("arst_stall", {31'd0, bus.md_stall}, 32'd0);
                step();
                resetn = 1;
                return;
            end
        end
        step();
        idle_in();
    endtask

    int exp_zero_stall;
    int choice, k;
    logic [31:0] ra, rb;

    initial begin
        idle_in();
        step(); step();
        resetn = 1;
        step();

        do_div(0, 32'd100, 32'd7, 0, 0);
        chk("divu100_7_stall_len", stall_seen, 34);
        chk("divu100_7_lo", bus.lo, 32'd14);
        chk("divu100_7_hi", bus.hi, 32'd2);

        do_div(1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_neg7_2_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_neg7_2_hi", bus.hi, 32'hFFFF_FFFF);

        do_div(0, 32'd50, 32'd5, 10, 0);
        chk("cancel_abort_pulses", abort_seen, 1);
        chk("cancel_hi_kept", bus.hi, 32'hFFFF_FFFF);
        chk("cancel_lo_kept", bus.lo, 32'hFFFF_FFFD);
        do_div(0, 32'd9, 32'd3, 0, 0);
        chk("divu9_3_stall_len", stall_seen, 34);
        chk("divu9_3_lo", bus.lo, 32'd3);
        chk("divu9_3_hi", bus.hi, 32'd0);

        stall_seen = 0;
        bus.op_valid = 1; bus.op_mthi = 1; bus.op_a = 32'h1234;
        step();
        chk("mthi_hi", bus.hi, 32'h1234);
        bus.op_mthi = 0; bus.op_mtlo = 1; bus.op_a = 32'hABCD;
        step();
        chk("mtlo_lo", bus.lo, 32'hABCD);
        chk("mthi_still", bus.hi, 32'h1234);
        idle_in();
        chk("mt_no_stall", stall_seen, 0);

`ifdef DIV_ZERO_SKIP_EN
        exp_zero_stall = 0;
`else
        exp_zero_stall = 34;
`endif
        do_div(0, 32'd8, 32'd0, 0, 0);
        chk("divu8_0_stall_len", stall_seen, exp_zero_stall);

        do_div(0, 32'd1000, 32'd3, 0, 20);
        step();
        do_div(0, 32'd7, 32'd7, 0, 0);
        chk("divu7_7_stall_len", stall_seen, 34);
        chk("divu7_7_lo", bus.lo, 32'd1);
        chk("divu7_7_hi", bus.hi, 32'd0);

        // randomized operation stream, checked every cycle by the model
        for (int n = 0; n < 60; n++) begin
            choice = $urandom_range(0, 7);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            case (choice)
                0: begin idle_in(); repeat ($urandom_range(1, 3)) step(); end
                1, 2: begin
                    bus.op_valid = 1; bus.op_mthi = (choice == 1); bus.op_mtlo = (choice == 2);
                    bus.op_a = ra; bus.cancel = ($urandom_range(0, 3) == 0);
                    step(); idle_in();
                end
                default: begin
                    k = 0;
                    if ($urandom_range(0, 3) == 0) k = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 33));
                    do_div(logic'($urandom_range(0, 1)), ra, rb, k, 0);
                end
            endcase
        end
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
